disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter MIN_HOLD, default 4: minimum number of consecutive cycles a grant stays asserted (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 16: grant age, in cycles, after which a contended owner is preempted (legal range MIN_HOLD..255; used only under REQ-024).
REQ-003 Parameter IDLE_VALUE, default 16'h0000: four nibbles shown when no requester owns the display, ordered [15:12]=thousands down to [3:0]=units.
REQ-004 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous and active-high.
REQ-006 req_a_i  in  1  requester A wants the display.
REQ-007 data_a_i  in  16  requester A digits, [15:12]=thousands, [11:8]=hundreds, [7:4]=tens, [3:0]=units.
REQ-008 req_b_i  in  1  requester B wants the display.
REQ-009 data_b_i  in  16  requester B digits, same nibble order as data_a_i.
REQ-010 gnt_a_o / gnt_b_o  out  1 each  registered grant to A / B; never both high.
REQ-011 dig1000_o, dig100_o, dig10_o, dig1_o  out  4 each  registered digits driving the 7-segment scan driver.
REQ-012 owner_o  out  2  owner code: 00 none, 01 A, 10 B; 11 never driven.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, OWN_A and OWN_B; owner_o, gnt_a_o and gnt_b_o are decoded from registered state.
REQ-014 In IDLE with exactly one request sampled high, the FSM SHALL move to that requester's OWN state at the same edge, so the grant is high one cycle after the request is first seen.
REQ-015 In IDLE with both requests high, the FSM SHALL grant the requester not served last (round-robin pointer); the pointer SHALL favour A after reset.
REQ-016 On entry to an OWN state, the digits SHALL load the owner's data at that same edge.
REQ-017 While owned, the digits SHALL reload from the owner's data at every edge where the owner's request is high, and SHALL hold their last value while it is low.
REQ-018 A 8-bit age counter SHALL clear on every grant, increment each owned cycle, and saturate at 255.
REQ-019 The grant SHALL stay high for at least MIN_HOLD consecutive cycles, even if the owner's request drops earlier.
REQ-020 Release SHALL occur at the first edge where the owner's request is low and age >= MIN_HOLD-1; if the other request is high at that edge, the FSM SHALL move directly to the other OWN state (no IDLE cycle); otherwise it SHALL move to IDLE.
REQ-021 On entry to IDLE, the digits SHALL load IDLE_VALUE.
REQ-022 Nibble values 4'hA..4'hF SHALL pass through unmodified.
REQ-023 The round-robin pointer SHALL update to the granted requester on every grant.

Configuration
REQ-024 With macro DISP_ARBITER_TIMEOUT_EN defined, an owner whose age >= TIMEOUT-1 while the other request is high SHALL be preempted at that edge and the FSM SHALL switch directly to the other OWN state; without it, an owner holds the display for as long as its request stays high and no preemption logic exists.

Reset
REQ-025 At a rising edge with rst_i high, the block SHALL enter IDLE with: gnt_a_o=0, gnt_b_o=0, owner_o=00, digits=IDLE_VALUE, age=0, pointer favouring A.
REQ-026 Reset SHALL override all other events, including a mid-grant state, a pending switch or a pending preemption.

Verification
REQ-027 Reset, then req_a_i=1 with data_a_i=16'h1234 -> gnt_a_o=1 one cycle later; digits read 1,2,3,4; owner_o=01.
REQ-028 A owns; req_a_i dropped after 1 cycle, B idle -> gnt_a_o high exactly 4 cycles (MIN_HOLD=4), then IDLE with digits 0,0,0,0.
REQ-029 Both requests rise together from reset -> A granted; A drops while B is high -> gnt_b_o rises on the release edge with no IDLE cycle; next simultaneous request from IDLE -> A granted.
REQ-030 A owns; data_a_i changes 16'h0001 -> 16'h0002 -> 16'h0003, then req_a_i drops during hold -> digits track each value, then freeze at 0003.
REQ-031 DISP_ARBITER_TIMEOUT_EN defined, A holds req continuously, B requests at grant age 3 -> B granted after A has held 16 cycles; macro undefined -> A keeps the grant indefinitely.
REQ-032 rst_i pulsed during OWN_B -> next cycle: grants 0, owner_o=00, digits=IDLE_VALUE.

Source files
------------

// File: rtl/disp_arbiter_if.sv
// ----------------------------------------------------------------------------
// disp_arbiter_if
// Purpose : groups the two requester channels and the display-side outputs
//           of disp_arbiter into one bundle.
// Signals :
//   req_a_i, data_a_i[15:0]   requester A request and BCD-style digits
//   req_b_i, data_b_i[15:0]   requester B request and digits
//   gnt_a_o, gnt_b_o          grants (never both high)
//   dig1000_o..dig1_o [3:0]   digits for the 7-segment scan driver
//   owner_o[1:0]              00 none, 01 A, 10 B
// Modports:
//   slave  - the arbiter (consumes requests, drives grants/digits)
//   master - the environment (drives requests, observes grants/digits)
// ----------------------------------------------------------------------------
interface disp_arbiter_if;
    logic        req_a_i;
    logic [15:0] data_a_i;
    logic        req_b_i;
    logic [15:0] data_b_i;
    logic        gnt_a_o;
    logic        gnt_b_o;
    logic [3:0]  dig1000_o;
    logic [3:0]  dig100_o;
    logic [3:0]  dig10_o;
    logic [3:0]  dig1_o;
    logic [1:0]  owner_o;

    modport slave (
        input  req_a_i, data_a_i, req_b_i, data_b_i,
        output gnt_a_o, gnt_b_o, dig1000_o, dig100_o, dig10_o, dig1_o, owner_o
    );

    modport master (
        output req_a_i, data_a_i, req_b_i, data_b_i,
        input  gnt_a_o, gnt_b_o, dig1000_o, dig100_o, dig10_o, dig1_o, owner_o
    );
endinterface

// File: rtl/disp_arbiter.sv
// ----------------------------------------------------------------------------
// disp_arbiter
// Purpose : arbitrates two requesters (A, B) for one 4-digit 7-segment
//           display. A grant lasts at least MIN_HOLD cycles; simultaneous
//           requests from IDLE are resolved round-robin (A favoured after
//           reset). The owner's digits are registered and reloaded while its
//           request is high, frozen while it is low.
// Ports   :
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - disp_arbiter_if.slave (requests, data, grants, digits, owner)
// Parameters:
//   MIN_HOLD   (1..255)         minimum grant length in cycles
//   TIMEOUT    (MIN_HOLD..255)  grant age at which a contended owner is
//                               preempted (timeout build only)
//   IDLE_VALUE                  digits shown when nobody owns the display
// Build option:
//   DISP_ARBITER_TIMEOUT_EN - when defined, an owner whose age reaches
//   TIMEOUT-1 while the other side requests is preempted. When undefined no
//   preemption logic exists and an owner keeps the display while requesting.
// ----------------------------------------------------------------------------
module disp_arbiter #(
    parameter int          MIN_HOLD   = 4,
    parameter int          TIMEOUT    = 16,
    parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    disp_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10
    } state_t;

    // Ages are compared against "limit - 1": age is 0 in the first owned
    // cycle, so a release at age MIN_HOLD-1 yields exactly MIN_HOLD cycles.
    localparam logic [7:0] HOLD_AGE    = 8'(MIN_HOLD - 1);
    localparam logic [7:0] TIMEOUT_AGE = 8'(TIMEOUT - 1);

    if (MIN_HOLD < 1 || MIN_HOLD > 255 || TIMEOUT < MIN_HOLD || TIMEOUT > 255) begin : g_bad_params
        $error("disp_arbiter: MIN_HOLD/TIMEOUT out of range");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_age;
    logic        r_last_b;      // 1: B was granted last, so A is favoured
    logic [15:0] r_digits;
    logic [15:0] w_digits_nxt;

    logic        w_own_req;
    logic        w_other_req;
    state_t      w_other_state;
    logic        w_release;
    logic        w_preempt;
    logic        w_grant;

    assign w_own_req     = (r_state == ST_OWN_A) ? bus.req_a_i : bus.req_b_i;
    assign w_other_req   = (r_state == ST_OWN_A) ? bus.req_b_i : bus.req_a_i;
    assign w_other_state = (r_state == ST_OWN_A) ? ST_OWN_B : ST_OWN_A;
    assign w_release     = !w_own_req && (r_age >= HOLD_AGE);

`ifdef DISP_ARBITER_TIMEOUT_EN
    assign w_preempt = w_other_req && (r_age >= TIMEOUT_AGE);
`else
    assign w_preempt = 1'b0;
`endif

    // A grant is any move into an OWN state, including a direct A<->B switch.
    assign w_grant = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: w_state_nxt gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_a_i && bus.req_b_i) begin
                    w_state_nxt = r_last_b ? ST_OWN_A : ST_OWN_B;
                end else if (bus.req_a_i) begin
                    w_state_nxt = ST_OWN_A;
                end else if (bus.req_b_i) begin
                    w_state_nxt = ST_OWN_B;
                end
            end
            ST_OWN_A, ST_OWN_B: begin
                if (w_release) begin
                    w_state_nxt = w_other_req ? w_other_state : ST_IDLE;
                end else if (w_preempt) begin
                    w_state_nxt = w_other_state;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        bus.gnt_a_o = (r_state == ST_OWN_A);
        bus.gnt_b_o = (r_state == ST_OWN_B);
        case (r_state)
            ST_OWN_A: bus.owner_o = 2'b01;
            ST_OWN_B: bus.owner_o = 2'b10;
            default:  bus.owner_o = 2'b00;
        endcase
    end

    // ---------------- digit datapath ----------------
    // Load on entry to a state; while owned, reload only when the owner is
    // requesting, otherwise freeze the last shown value.
    always_comb begin
        w_digits_nxt = r_digits;
        case (w_state_nxt)
            ST_IDLE:  if (r_state != ST_IDLE)        w_digits_nxt = IDLE_VALUE;
            ST_OWN_A: if (w_grant || bus.req_a_i)    w_digits_nxt = bus.data_a_i;
            ST_OWN_B: if (w_grant || bus.req_b_i)    w_digits_nxt = bus.data_b_i;
            default:  w_digits_nxt = IDLE_VALUE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_age    <= 8'd0;
            r_last_b <= 1'b1;
            r_digits <= IDLE_VALUE;
        end else begin
            if (w_grant) begin
                r_age    <= 8'd0;
                r_last_b <= (w_state_nxt == ST_OWN_B);
            end else if (r_state != ST_IDLE && r_age != 8'hFF) begin
                r_age <= r_age + 8'd1;
            end
            r_digits <= w_digits_nxt;
        end
    end

    assign bus.dig1000_o = r_digits[15:12];
    assign bus.dig100_o  = r_digits[11:8];
    assign bus.dig10_o   = r_digits[7:4];
    assign bus.dig1_o    = r_digits[3:0];

endmodule

// File: tb/tb_disp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_disp_arbiter
// Directed bench for disp_arbiter with default parameters (MIN_HOLD=4,
// TIMEOUT=16, IDLE_VALUE=0). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so each step() shows the state
// produced by exactly one edge.
// ----------------------------------------------------------------------------
module tb_disp_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    disp_arbiter_if bus ();

    disp_arbiter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] w_digits;
    assign w_digits = {bus.dig1000_o, bus.dig100_o, bus.dig10_o, bus.dig1_o};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.data_a_i = 16'h9999;
        bus.data_b_i = 16'h8888;
        do_reset();
        n_checks++;
        if ({bus.gnt_a_o, bus.gnt_b_o, bus.owner_o} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_grants: got gnt=%b%b owner=%b, want 00/00",
                     bus.gnt_a_o, bus.gnt_b_o, bus.owner_o);
        end
        n_checks++;
        if (w_digits !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_digits: got %h, want 0000", w_digits);
        end
    endtask

    // Single request: grant one cycle later, then minimum hold after drop.
    task automatic test_single_and_hold();
        int cnt;
        bus.req_a_i  = 1'b1;
        bus.data_a_i = 16'h1234;
        step();
        n_checks++;
        if (bus.gnt_a_o !== 1'b1 || bus.owner_o !== 2'b01 || w_digits !== 16'h1234) begin
            n_errors++;
            $display("FAIL single_grant: got gnt_a=%b owner=%b dig=%h, want 1/01/1234",
                     bus.gnt_a_o, bus.owner_o, w_digits);
        end
        bus.req_a_i  = 1'b0;
        bus.data_a_i = 16'h5555;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                n_checks++;
                if (w_digits !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL hold_freeze: got %h, want 1234", w_digits);
                end
            end
            if (bus.gnt_a_o) cnt++;
            else break;
        end
        n_checks++;
        if (cnt !== 4) begin
            n_errors++;
            $display("FAIL min_hold_len: got %0d cycles, want 4", cnt);
        end
        n_checks++;
        if (bus.owner_o !== 2'b00 || w_digits !== 16'h0000) begin
            n_errors++;
            $display("FAIL idle_after_hold: got owner=%b dig=%h, want 00/0000",
                     bus.owner_o, w_digits);
        end
    endtask

    task automatic test_round_robin();
        int cnt;
        bit idle_seen;
        do_reset();
        bus.data_a_i = 16'h1111;
        bus.data_b_i = 16'h2222;
        bus.req_a_i  = 1'b1;
        bus.req_b_i  = 1'b1;
        step();
        n_checks++;
        if (bus.gnt_a_o !== 1'b1 || bus.gnt_b_o !== 1'b0 || w_digits !== 16'h1111) begin
            n_errors++;
            $display("FAIL rr_first_a: got gnt=%b%b dig=%h, want a-granted/1111",
                     bus.gnt_a_o, bus.gnt_b_o, w_digits);
        end
        bus.req_a_i = 1'b0;
        cnt = 0;
        idle_seen = 1'b0;
        while (bus.gnt_b_o !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
            if (bus.owner_o === 2'b00) idle_seen = 1'b1;
        end
        n_checks++;
        if (cnt !== 4 || idle_seen) begin
            n_errors++;
            $display("FAIL switch_to_b: got %0d cycles idle_seen=%b, want 4/0", cnt, idle_seen);
        end
        n_checks++;
        if (bus.gnt_a_o !== 1'b0 || bus.owner_o !== 2'b10 || w_digits !== 16'h2222) begin
            n_errors++;
            $display("FAIL b_owns: got gnt_a=%b owner=%b dig=%h, want 0/10/2222",
                     bus.gnt_a_o, bus.owner_o, w_digits);
        end
        // B releases to IDLE, then a tie should go to A (B was served last).
        bus.req_b_i = 1'b0;
        repeat (4) step();
        n_checks++;
        if (bus.owner_o !== 2'b00) begin
            n_errors++;
            $display("FAIL b_release_idle: got owner=%b, want 00", bus.owner_o);
        end
        bus.req_a_i = 1'b1;
        bus.req_b_i = 1'b1;
        step();
        n_checks++;
        if (bus.owner_o !== 2'b01) begin
            n_errors++;
            $display("FAIL rr_tie_after_b: got owner=%b, want 01", bus.owner_o);
        end
        // A releases with B low, then a tie should go to B.
        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b0;
        repeat (4) step();
        bus.req_a_i = 1'b1;
        bus.req_b_i = 1'b1;
        step();
        n_checks++;
        if (bus.owner_o !== 2'b10 || w_digits !== 16'h2222) begin
            n_errors++;
            $display("FAIL rr_tie_after_a: got owner=%b dig=%h, want 10/2222",
                     bus.owner_o, w_digits);
        end
        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b0;
    endtask

    task automatic test_data_track();
        logic [15:0] vals [3] = '{16'h0001, 16'h0002, 16'h0003};
        do_reset();
        bus.req_a_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_a_i = vals[i];
            step();
            n_checks++;
            if (w_digits !== vals[i]) begin
                n_errors++;
                $display("FAIL track_%0d: got %h, want %h", i, w_digits, vals[i]);
            end
        end
        bus.req_a_i  = 1'b0;
        bus.data_a_i = 16'h0009;
        step();
        n_checks++;
        if (bus.gnt_a_o !== 1'b1 || w_digits !== 16'h0003) begin
            n_errors++;
            $display("FAIL track_freeze: got gnt_a=%b dig=%h, want 1/0003", bus.gnt_a_o, w_digits);
        end
        step();
        n_checks++;
        if (bus.owner_o !== 2'b00 || w_digits !== 16'h0000) begin
            n_errors++;
            $display("FAIL track_release: got owner=%b dig=%h, want 00/0000", bus.owner_o, w_digits);
        end
    endtask

    task automatic test_hex_and_reset_mid_grant();
        do_reset();
        bus.data_b_i = 16'hFEDC;
        bus.req_b_i  = 1'b1;
        step();
        n_checks++;
        if (bus.owner_o !== 2'b10 || w_digits !== 16'hFEDC) begin
            n_errors++;
            $display("FAIL hex_pass: got owner=%b dig=%h, want 10/fedc", bus.owner_o, w_digits);
        end
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_checks++;
        if ({bus.gnt_a_o, bus.gnt_b_o, bus.owner_o} !== 4'b0000 || w_digits !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_mid_b: got gnt=%b%b owner=%b dig=%h, want 00/00/0000",
                     bus.gnt_a_o, bus.gnt_b_o, bus.owner_o, w_digits);
        end
        bus.req_b_i = 1'b0;
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        bus.data_a_i = 16'h1234;
        bus.data_b_i = 16'hABCD;
        bus.req_a_i  = 1'b1;
        step();
        cnt = 1;
        repeat (3) begin
            step();
            cnt++;
        end
        bus.req_b_i = 1'b1;   // A's age is 3 here
        while (bus.gnt_b_o !== 1'b1 && cnt < 40) begin
            step();
            if (bus.gnt_a_o) cnt++;
        end
`ifdef DISP_ARBITER_TIMEOUT_EN
        n_checks++;
        if (cnt !== 16 || bus.gnt_b_o !== 1'b1 || w_digits !== 16'hABCD) begin
            n_errors++;
            $display("FAIL timeout_preempt: got a_cycles=%0d gnt_b=%b dig=%h, want 16/1/abcd",
                     cnt, bus.gnt_b_o, w_digits);
        end
`else
        n_checks++;
        if (cnt !== 40 || bus.gnt_a_o !== 1'b1 || bus.gnt_b_o !== 1'b0) begin
            n_errors++;
            $display("FAIL no_timeout_hold: got a_cycles=%0d gnt=%b%b, want 40/10",
                     cnt, bus.gnt_a_o, bus.gnt_b_o);
        end
`endif
        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b0;
    endtask

    initial begin
        bus.req_a_i  = 1'b0;
        bus.req_b_i  = 1'b0;
        bus.data_a_i = 16'h0000;
        bus.data_b_i = 16'h0000;
        #2;
        test_reset();
        test_single_and_hold();
        test_round_robin();
        test_data_track();
        test_hex_and_reset_mid_grant();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
